core_trace_buf: RTL and testbench

//   Retire-trace buffer that sits directly downstream of the core and records
//   one entry per retired instruction: pc, inst, wb_addr and wb_data.

---
 rtl/core_trace_buf.sv | 141 ++++++++++++++
 tb/tb_core_trace_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_trace_buf.sv
// Retire-trace buffer: captures one record per retired instruction into a
// first-word-fall-through FIFO and drains it to a trace sink until program exit.
module core_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic [4:0]      in_wb_addr,
  input  logic [XLEN-1:0] in_wb_data,
  input  logic            in_exit,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_wb_addr,
  output logic [XLEN-1:0] out_wb_data,
  output logic [AW:0]     level,
  output logic [15:0]     drop_cnt,
  output logic            done
);

  localparam int EW = 2 * XLEN + 37;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW:0]     level_r;
  logic [AW:0]     level_next_s;
  logic [15:0]     drop_cnt_r;
  logic            out_valid_r;
  logic            done_r;
  logic [EW-1:0]   mem_r [DEPTH];
  logic [EW-1:0]   head_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_s;
  logic            full_s;
  logic            run_s;

  assign run_s  = (state_r == ST_RUN);
  assign full_s = (level_r == FULL_LVL);
  assign pop_s  = out_valid_r & out_ready;
  // A full buffer still accepts a record when the head leaves in the same cycle.
  assign push_s = in_valid & run_s & (~full_s | pop_s);
  assign drop_s = in_valid & run_s & full_s & ~pop_s;

  // Occupancy update for push-only, pop-only, both or neither.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + {{AW{1'b0}}, 1'b1};
      2'b01:   level_next_s = level_r - {{AW{1'b0}}, 1'b1};
      default: level_next_s = level_r;
    endcase
  end

  // Next-state logic for capture / drain / finished phases.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (in_exit) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((level_r == {(AW + 1){1'b0}}) ||
            ((level_r == {{AW{1'b0}}, 1'b1}) && pop_s)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_next_s = ST_DONE;
      default:  state_next_s = ST_RUN;
    endcase
  end

  // Control state: FSM, pointers, occupancy, drop counter and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      rd_ptr_r    <= {AW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      level_r     <= {(AW + 1){1'b0}};
      drop_cnt_r  <= 16'h0000;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      level_r     <= level_next_s;
      out_valid_r <= (level_next_s != {(AW + 1){1'b0}});
      done_r      <= (state_next_s == ST_DONE);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'h0001;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  // Record storage; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_pc, in_inst, in_wb_addr, in_wb_data};
    end
  end

  assign head_s = mem_r[rd_ptr_r];
  assign {out_pc, out_inst, out_wb_addr, out_wb_data} = head_s;
  assign out_valid = out_valid_r;
  assign level     = level_r;
  assign drop_cnt  = drop_cnt_r;
  assign done      = done_r;

endmodule

// File: tb/tb_core_trace_buf.sv
// Directed self-checking bench for core_trace_buf: a vector table for basic
// FIFO behaviour plus hand-written sequences for overflow, wrap, exit and reset.
module tb_core_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  in_wb_addr;
  logic [31:0] in_wb_data;
  logic        in_exit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_wb_addr;
  logic [31:0] out_wb_data;
  logic [4:0]  level;
  logic [15:0] drop_cnt;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  core_trace_buf #(.XLEN(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wb_addr(in_wb_addr), .in_wb_data(in_wb_data), .in_exit(in_exit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_wb_addr(out_wb_addr),
    .out_wb_data(out_wb_data), .level(level), .drop_cnt(drop_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic [4:0]  exp_level;
    logic        exp_ov;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Companion fields are derived from pc so the whole record can be checked.
  task automatic set_in(input logic v, input logic [31:0] pc, input logic rdy, input logic ex);
    logic [31:0] wd;
    wd         = pc * 32'd3 + 32'd1;
    in_valid   = v;
    in_pc      = pc;
    in_inst    = ~pc;
    in_wb_addr = pc[6:2];
    in_wb_data = wd;
    out_ready  = rdy;
    in_exit    = ex;
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    logic [31:0] wa;
    wa = {27'd0, pc[6:2]};
    chk({name, "_pc"}, out_pc, pc);
    chk({name, "_inst"}, out_inst, ~pc);
    chk({name, "_wba"}, {27'd0, out_wb_addr}, wa);
    chk({name, "_wbd"}, out_wb_data, pc * 32'd3 + 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // valid, pc, ready, exp level, exp out_valid, check head?, exp head pc
    vecs[0] = '{1'b1, 32'h0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h0};
    vecs[1] = '{1'b1, 32'h4, 1'b0, 5'd2, 1'b1, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 32'h8, 1'b0, 5'd3, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 5'd2, 1'b1, 1'b1, 32'h4};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 5'd1, 1'b1, 1'b1, 32'h8};
    vecs[5] = '{1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'hC, 1'b1, 5'd1, 1'b1, 1'b1, 32'hC};
    vecs[7] = '{1'b1, 32'h10, 1'b1, 5'd1, 1'b1, 1'b1, 32'h10};
    vecs[8] = '{1'b0, 32'h0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0};

    do_reset();
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);

    // Basic pushes, pops, and push-while-empty with ready high.
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].v, vecs[i].pc, vecs[i].rdy, 1'b0);
      tick();
      chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, vecs[i].exp_level});
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
      if (vecs[i].chk_pc) chk_head($sformatf("vec%0d", i), vecs[i].exp_pc);
    end

    // Overflow: 20 pushes into 16 entries, then push+pop on a full buffer.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, i * 4, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 32'd0, 1'b0, 1'b0);
    chk("full_level", {27'd0, level}, 32'd16);
    chk("full_drop", {16'd0, drop_cnt}, 32'd4);
    chk_head("full_head", 32'h0);
    set_in(1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    chk("fullpp_level", {27'd0, level}, 32'd16);
    chk("fullpp_drop", {16'd0, drop_cnt}, 32'd4);
    set_in(1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk_head($sformatf("drain%0d", i), i * 4);
      tick();
    end
    chk_head("drain_last", 32'h40);
    tick();
    chk("drained_level", {27'd0, level}, 32'd0);
    chk("drained_ov", {31'd0, out_valid}, 32'd0);
    chk("drained_drop", {16'd0, drop_cnt}, 32'd4);

    // Streaming with pointer wrap: each record leaves one cycle after entry.
    for (int i = 0; i < 40; i++) begin
      set_in(1'b1, 32'h1000 + i * 4, 1'b1, 1'b0);
      tick();
      chk($sformatf("wrap%0d_pc", i), out_pc, 32'h1000 + i * 4);
      chk($sformatf("wrap%0d_level", i), {27'd0, level}, 32'd1);
    end
    set_in(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("wrap_end_level", {27'd0, level}, 32'd0);

    // Exit with a record in the same cycle, drain, then sticky done.
    do_reset();
    set_in(1'b1, 32'h20, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h24, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h44, 1'b0, 1'b1); tick();
    chk("exit_level", {27'd0, level}, 32'd3);
    chk("exit_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = (k == 0) ? 32'h20 : ((k == 1) ? 32'h24 : 32'h44);
      set_in(1'b1, 32'h99, 1'b1, 1'b1);
      chk_head($sformatf("exitdrain%0d", k), exp_pc);
      tick();
      chk($sformatf("exitdrain%0d_done", k), {31'd0, done}, (k == 2) ? 32'd1 : 32'd0);
    end
    chk("exit_end_level", {27'd0, level}, 32'd0);
    chk("exit_end_drop", {16'd0, drop_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 32'h100 + k * 4, 1'b1, 1'b0);
      tick();
      chk($sformatf("done_hold%0d", k), {31'd0, done}, 32'd1);
      chk($sformatf("done_lvl%0d", k), {27'd0, level}, 32'd0);
      chk($sformatf("done_drop%0d", k), {16'd0, drop_cnt}, 32'd0);
    end

    // Asynchronous reset in the middle of a drain.
    do_reset();
    set_in(1'b1, 32'h20, 1'b0, 1'b0); tick();
    set_in(1'b1, 32'h24, 1'b0, 1'b0); tick();
    set_in(1'b0, 32'h0, 1'b0, 1'b1); tick();
    set_in(1'b0, 32'h0, 1'b1, 1'b1); tick();
    chk("middrain_level", {27'd0, level}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", {31'd0, out_valid}, 32'd0);
    chk("arst_level", {27'd0, level}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 32'h80, 1'b0, 1'b0);
    tick();
    chk("postrst_level", {27'd0, level}, 32'd1);
    chk("postrst_ov", {31'd0, out_valid}, 32'd1);
    chk_head("postrst", 32'h80);

    // Exit while empty: DRAIN for one cycle, then DONE.
    do_reset();
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk("empty_exit_done0", {31'd0, done}, 32'd0);
    tick();
    chk("empty_exit_done1", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
